// File: rtl/decode_queue_pkg.sv
// ============================================================================
// Module : decode_pkg
// Brief  : Shared types and constants for the RV32I decode queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_ZERO = 2'd1,
        A_PC   = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    typedef struct packed {
        logic       reg_wr_en;
        logic       mem_wr_en;
        logic [2:0] imm_src;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic [3:0] byte_en;
        logic [1:0] a_sel;
        logic       signed_;
        logic       muldiv;
        logic       illegal;
    } ctrl_t;

    // Access size (funct3[1:0]) to byte-lane enables; size 3 has no lanes.
    function automatic logic [3:0] mem_byte_en(input logic [1:0] size);
        case (size)
            2'd0:    mem_byte_en = 4'b0001;
            2'd1:    mem_byte_en = 4'b0011;
            2'd2:    mem_byte_en = 4'b1111;
            default: mem_byte_en = 4'b0000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_queue_decode.sv
// ============================================================================
// Module : rv32_decode_comb
// Brief  : Pure combinational RV32I instruction -> ctrl_t decoder.
//          Macro RV32M_EN enables decoding of the M extension (funct7=0x01).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32_decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        case (opcode)
            OPC_LOAD: begin
                ctrl.reg_wr_en  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.byte_en    = mem_byte_en(funct3[1:0]);
                ctrl.signed_    = ~funct3[2];
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)
                    legal = 1'b0;
            end
            OPC_OP_IMM: begin
                ctrl.reg_wr_en = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.signed_   = (funct3 != 3'd3);
                if (funct3 == 3'd1) begin
                    ctrl.imm_src = IMM_SHAMT;
                    if (funct7 != 7'h00)
                        legal = 1'b0;
                end else if (funct3 == 3'd5) begin
                    ctrl.imm_src = IMM_SHAMT;
                    if (funct7 != 7'h00 && funct7 != 7'h20)
                        legal = 1'b0;
                end else begin
                    ctrl.imm_src = IMM_I;
                end
            end
            OPC_STORE: begin
                ctrl.mem_wr_en = 1'b1;
                ctrl.imm_src   = IMM_S;
                ctrl.byte_en   = mem_byte_en(funct3[1:0]);
                if (funct3 > 3'd2)
                    legal = 1'b0;
            end
            OPC_OP: begin
                ctrl.reg_wr_en = 1'b1;
                ctrl.alu_op    = ALUOP_R;
                case (funct7)
                    7'h00: legal = 1'b1;
                    7'h20: legal = (funct3 == 3'd0 || funct3 == 3'd5);
`ifdef RV32M_EN
                    7'h01: ctrl.muldiv = 1'b1;
`else
                    7'h01: legal = 1'b0;
`endif
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.imm_src = IMM_B;
                ctrl.alu_op  = ALUOP_BR;
                ctrl.signed_ = (funct3 != 3'd6 && funct3 != 3'd7);
                if (funct3 == 3'd2 || funct3 == 3'd3)
                    legal = 1'b0;
            end
            OPC_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_wr_en  = 1'b1;
                ctrl.imm_src    = IMM_J;
                ctrl.result_src = RES_PC4;
            end
            OPC_JALR: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_wr_en  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
                if (funct3 != 3'd0)
                    legal = 1'b0;
            end
            OPC_LUI: begin
                ctrl.reg_wr_en = 1'b1;
                ctrl.imm_src   = IMM_U;
                ctrl.a_sel     = A_ZERO;
            end
            OPC_AUIPC: begin
                ctrl.reg_wr_en = 1'b1;
                ctrl.imm_src   = IMM_U;
                ctrl.a_sel     = A_PC;
            end
            default: legal = 1'b0;
        endcase

        if (instr[1:0] != 2'b11)
            legal = 1'b0;

        // Illegal bundles carry only the illegal flag so execute never acts on them.
        if (!legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_queue.sv
// ============================================================================
// Module : decode_queue
// Brief  : RV32I decoder followed by a DEPTH-entry valid/ready queue with
//          flush and a saturating illegal-instruction counter.
//          Macro RV32M_EN (in rv32_decode_comb) enables M-extension decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_queue
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output ctrl_t            out_ctrl_o,
    output logic [31:0]      out_instr_o,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    ctrl_t            dec_ctrl;
    ctrl_t            ctrl_mem  [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] illegal_cnt;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    rv32_decode_comb u_decode (
        .instr (instr_i),
        .ctrl  (dec_ctrl)
    );

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    // Same slot, opposite lap: the writer is a full lap ahead of the reader.
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    // in_ready depends only on state, so a same-cycle pop cannot open a full queue.
    assign push = in_valid_i & ~full & ~flush_i;
    assign pop  = ~empty & out_ready_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_idx]  <= dec_ctrl;
            instr_mem[wr_idx] <= instr_i;
            pc_mem[wr_idx]    <= pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (push && dec_ctrl.illegal && (illegal_cnt != {CNT_W{1'b1}}))
            illegal_cnt <= illegal_cnt + CNT_W'(1);
    end

    assign in_ready_o    = ~full;
    assign out_valid_o   = ~empty;
    assign out_ctrl_o    = empty ? '0 : ctrl_mem[rd_idx];
    assign out_instr_o   = empty ? '0 : instr_mem[rd_idx];
    assign out_pc_o      = empty ? '0 : pc_mem[rd_idx];
    assign illegal_cnt_o = illegal_cnt;

endmodule

`default_nettype wire
